// File: rtl/lib_allocator_islip_multi_if.sv
// Request/grant bundle between the VOQ request logic and the iSLIP allocator.
//   i_start    : start an allocation (sampled by the allocator only when idle)
//   i_request  : N vectors of M bits, i_request[n][m] = input n wants output m
//   o_busy     : allocation in progress or result being reported
//   o_done     : one-cycle pulse, o_grant is complete
//   o_grant    : M vectors of N bits, o_grant[m][n] = output m matched to input n
// master = requester side, slave = allocator side.
interface lib_allocator_islip_multi_if #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
);
  logic         i_start;
  logic [M-1:0] i_request [N];
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_grant [M];

  modport master (
    output i_start,
    output i_request,
    input  o_busy,
    input  o_done,
    input  o_grant
  );

  modport slave (
    input  i_start,
    input  i_request,
    output o_busy,
    output o_done,
    output o_grant
  );
endinterface

// File: rtl/lib_allocator_islip_multi.sv
// Iterative NxM iSLIP allocator. One request-grant-accept iteration per cycle, up to ITER
// iterations, building a conflict-free matching in o_grant.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of lib_allocator_islip_multi_if (start/request in, busy/done/grant out)
module lib_allocator_islip_multi #(
  parameter int unsigned N    = 4,
  parameter int unsigned M    = 4,
  parameter int unsigned ITER = 3
) (
  input logic                        clk,
  input logic                        reset_n,
  lib_allocator_islip_multi_if.slave bus
);

  localparam int unsigned GntPtrW = $clog2(N);
  localparam int unsigned AccPtrW = $clog2(M);
  localparam int unsigned CntW    = $clog2(ITER + 1);
  localparam int unsigned MaxW    = (N > M) ? N : M;

  typedef enum logic [1:0] {StIdle, StIterate, StDone} state_e;

  // First set bit of cand at or after ptr, wrapping to the lowest set bit otherwise.
  function automatic logic [MaxW-1:0] rr_pick(input logic [MaxW-1:0] cand,
                                              input int unsigned   ptr);
    logic [MaxW-1:0] hi;
    logic [MaxW-1:0] lo;
    hi = '0;
    lo = '0;
    for (int unsigned j = 0; j < MaxW; j++) begin
      if (cand[j] && (lo == '0)) lo[j] = 1'b1;
      if (cand[j] && (hi == '0) && (j >= ptr)) hi[j] = 1'b1;
    end
    return (hi != '0) ? hi : lo;
  endfunction

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [M-1:0]       req_q   [N];
  logic [N-1:0]       grant_q [M];
  logic [GntPtrW-1:0] g_q     [M];
  logic [AccPtrW-1:0] a_q     [N];

  logic [N-1:0]       in_matched;
  logic [M-1:0]       out_matched;
  logic [MaxW-1:0]    gnt_cand [M];
  logic [MaxW-1:0]    gnt_pick [M];
  logic [MaxW-1:0]    acc_cand [N];
  logic [MaxW-1:0]    acc_pick [N];
  logic [N-1:0]       grant_d  [M];
  logic [GntPtrW-1:0] g_d      [M];
  logic [AccPtrW-1:0] a_d      [N];
  logic               any_new;

  // One iSLIP iteration from the registered match state.
  always_comb begin
    for (int unsigned m = 0; m < M; m++) begin
      out_matched[m] = |grant_q[m];
    end
    for (int unsigned n = 0; n < N; n++) begin
      in_matched[n] = 1'b0;
      for (int unsigned m = 0; m < M; m++) begin
        in_matched[n] = in_matched[n] | grant_q[m][n];
      end
    end

    // Grant: each unmatched output picks among still-unmatched requesting inputs.
    for (int unsigned m = 0; m < M; m++) begin
      gnt_cand[m] = '0;
      for (int unsigned n = 0; n < N; n++) begin
        gnt_cand[m][n] = req_q[n][m] & ~in_matched[n] & ~out_matched[m];
      end
      gnt_pick[m] = rr_pick(gnt_cand[m], 32'(g_q[m]));
    end

    // Accept: each input picks one of the outputs that granted it.
    for (int unsigned n = 0; n < N; n++) begin
      acc_cand[n] = '0;
      for (int unsigned m = 0; m < M; m++) begin
        acc_cand[n][m] = gnt_pick[m][n];
      end
      acc_pick[n] = rr_pick(acc_cand[n], 32'(a_q[n]));
    end

    any_new = 1'b0;
    grant_d = grant_q;
    g_d     = g_q;
    a_d     = a_q;
    for (int unsigned n = 0; n < N; n++) begin
      for (int unsigned m = 0; m < M; m++) begin
        if (acc_pick[n][m]) begin
          grant_d[m][n] = 1'b1;
          any_new       = 1'b1;
          // Pointers only move on first-iteration accepts; this is what desynchronises them.
          if (cnt_q == CntW'(1)) begin
            g_d[m] = GntPtrW'((n + 1) % N);
            a_d[n] = AccPtrW'((m + 1) % M);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= '{default: '0};
      grant_q <= '{default: '0};
      g_q     <= '{default: '0};
      a_q     <= '{default: '0};
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.i_start) begin
            req_q   <= bus.i_request;
            grant_q <= '{default: '0};
            cnt_q   <= CntW'(1);
            busy_q  <= 1'b1;
            state_q <= StIterate;
          end
        end
        StIterate: begin
          grant_q <= grant_d;
          g_q     <= g_d;
          a_q     <= a_d;
          if ((cnt_q == CntW'(ITER)) || !any_new) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_grant = grant_q;

endmodule

// File: tb/tb_lib_allocator_islip_multi.sv
// Bench for lib_allocator_islip_multi: an ITER=3 and an ITER=1 instance, 4x4. Expected matchings
// and latencies are pushed to a scoreboard at start and compared when o_done arrives.
// Request words: bit 4*n+m = input n requests output m. Grant words: bit 4*m+n = o_grant[m][n].
module tb_lib_allocator_islip_multi;
  localparam int unsigned N = 4;
  localparam int unsigned M = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lib_allocator_islip_multi_if #(.N(N), .M(M)) bus0 ();
  lib_allocator_islip_multi_if #(.N(N), .M(M)) bus1 ();

  lib_allocator_islip_multi #(.N(N), .M(M), .ITER(3)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  lib_allocator_islip_multi #(.N(N), .M(M), .ITER(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  typedef struct {
    logic [15:0] gnt;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mg[2][4];
  int   ma[2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs_gnt(input int d);
    logic [15:0] v;
    v = '0;
    for (int m = 0; m < 4; m++) begin
      v[4*m +: 4] = (d == 0) ? bus0.o_grant[m] : bus1.o_grant[m];
    end
    return v;
  endfunction

  function automatic logic obs_busy(input int d);
    return (d == 0) ? bus0.o_busy : bus1.o_busy;
  endfunction

  function automatic logic obs_done(input int d);
    return (d == 0) ? bus0.o_done : bus1.o_done;
  endfunction

  // 1 when some output or input carries more than one match.
  function automatic logic conflict(input logic [15:0] g);
    int cnt;
    for (int m = 0; m < 4; m++) begin
      if ($countones(g[4*m +: 4]) > 1) return 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      cnt = 0;
      for (int m = 0; m < 4; m++) cnt += int'(g[4*m+n]);
      if (cnt > 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_start(input int d, input logic s, input logic [15:0] req);
    for (int n = 0; n < 4; n++) begin
      if (d == 0) bus0.i_request[n] = req[4*n +: 4];
      else        bus1.i_request[n] = req[4*n +: 4];
    end
    if (d == 0) bus0.i_start = s;
    else        bus1.i_start = s;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        mg[d][k] = 0;
        ma[d][k] = 0;
      end
    end
  endtask

  // Behavioural iSLIP: searches by modular offset from each pointer.
  task automatic model_alloc(input int d, input int iter_max, input logic [15:0] req,
                             output logic [15:0] gnt, output int iters);
    bit in_m[4];
    bit out_m[4];
    int gsel[4];
    int added;
    int idx;
    int pick;
    gnt   = '0;
    iters = 0;
    for (int k = 0; k < 4; k++) begin
      in_m[k]  = 1'b0;
      out_m[k] = 1'b0;
    end
    for (int it = 1; it <= iter_max; it++) begin
      iters = it;
      added = 0;
      for (int m = 0; m < 4; m++) begin
        gsel[m] = -1;
        if (!out_m[m]) begin
          for (int k = 0; k < 4; k++) begin
            idx = (mg[d][m] + k) % 4;
            if (gsel[m] < 0 && !in_m[idx] && req[4*idx+m]) gsel[m] = idx;
          end
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (!in_m[n]) begin
          pick = -1;
          for (int k = 0; k < 4; k++) begin
            idx = (ma[d][n] + k) % 4;
            if (pick < 0 && gsel[idx] == n) pick = idx;
          end
          if (pick >= 0) begin
            gnt[4*pick+n] = 1'b1;
            in_m[n]       = 1'b1;
            out_m[pick]   = 1'b1;
            added++;
            if (it == 1) begin
              mg[d][pick] = (n + 1) % 4;
              ma[d][n]    = (pick + 1) % 4;
            end
          end
        end
      end
      if (added == 0) break;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the o_done cycle.
  task automatic run_alloc(input int d, input logic [15:0] req, input bit use_fixed,
                           input logic [15:0] fixed_gnt, input bit poke,
                           output logic [15:0] got);
    exp_t        e;
    logic [15:0] mgnt;
    int          iters;
    int          cyc;
    int          extra;
    bit          seen;
    model_alloc(d, (d == 0) ? 3 : 1, req, mgnt, iters);
    e.gnt = use_fixed ? fixed_gnt : mgnt;
    e.lat = iters + 1;
    sb.push_back(e);

    set_start(d, 1'b1, req);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // A start pulse with a different request while iterating must be ignored.
        set_start(d, poke, poke ? 16'hFFFF : req);
        check("busy_iter", 32'(obs_busy(d)), 32'd1);
      end
      if (cyc == 2) set_start(d, 1'b0, req);
      if (obs_done(d)) seen = 1'b1;
    end
    e   = sb.pop_front();
    got = obs_gnt(d);
    if (!seen) begin
      check("done_timeout", 32'd1, 32'd0);
    end else begin
      check("grant", 32'(got), 32'(e.gnt));
      check("latency", 32'(cyc), 32'(e.lat));
      check("busy_done", 32'(obs_busy(d)), 32'd1);
    end
    set_start(d, 1'b0, req);
    @(negedge clk);
    check("done_pulse", 32'(obs_done(d)), 32'd0);
    check("busy_idle", 32'(obs_busy(d)), 32'd0);
    check("grant_hold", 32'(obs_gnt(d)), 32'(e.gnt));
    if (poke) begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (obs_done(d)) extra++;
      end
      check("ignored_start", 32'(extra), 32'd0);
      check("grant_after_poke", 32'(obs_gnt(d)), 32'(e.gnt));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] rq;
    int          late_done;

    reset_n = 1'b0;
    set_start(0, 1'b0, 16'h0);
    set_start(1, 1'b0, 16'h0);
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus0.o_busy), 32'd0);
    check("rst_done", 32'(bus0.o_done), 32'd0);
    check("rst_grant0", 32'(obs_gnt(0)), 32'd0);
    check("rst_grant1", 32'(obs_gnt(1)), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full request twice from reset: diagonal of 3, then full permutation.
    run_alloc(0, 16'hFFFF, 1'b1, 16'h0421, 1'b0, got);
    run_alloc(0, 16'hFFFF, 1'b1, 16'h8412, 1'b0, got);

    // Single request input 2 -> output 1, stops after an empty second iteration.
    do_reset();
    run_alloc(0, 16'h0200, 1'b1, 16'h0040, 1'b0, got);
    // Zero request with an ignored start during ITERATE.
    run_alloc(0, 16'h0000, 1'b1, 16'h0000, 1'b1, got);
    // Pointers left by the single request (g[1]=3, a[2]=2) steer this one.
    run_alloc(0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, got);

    for (int i = 0; i < 6; i++) begin
      rq = 16'($urandom);
      run_alloc(0, rq, 1'b0, 16'h0000, 1'b0, got);
      check("rand_conflict", 32'(conflict(got)), 32'd0);
    end

    // Reset during the second iteration.
    set_start(0, 1'b1, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    set_start(0, 1'b0, 16'hFFFF);
    @(negedge clk);
    check("busy_mid", 32'(bus0.o_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus0.o_busy), 32'd0);
    check("mid_rst_done", 32'(bus0.o_done), 32'd0);
    check("mid_rst_grant", 32'(obs_gnt(0)), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.o_done) late_done++;
    end
    check("mid_rst_no_done", 32'(late_done), 32'd0);
    run_alloc(0, 16'hFFFF, 1'b1, 16'h0421, 1'b0, got);

    // Single-iteration instance: pointers desynchronise under full load.
    for (int a = 1; a <= 8; a++) begin
      run_alloc(1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, got);
      check("iter1_conflict", 32'(conflict(got)), 32'd0);
      if (a >= 5) check("iter1_full", 32'($countones(got)), 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
